// File: rtl/fpu_fcmp_pipe.sv
// fpu_fcmp_pipe: compare / min-max / sign-inject / classify unit for FP32.
// The result is formed combinationally from the operands and then carried
// through NUM_STAGES valid/ready register stages together with the tag.
// i_op is one-hot: [0]=FCMP [1]=FMINMAX [2]=FSGNJ [3]=FCLASS.
// o_fflags layout is {NV, DZ, OF, UF, NX}; only NV is ever raised.
module fpu_fcmp_pipe #(
   parameter int unsigned FP_FMT     = 0,   // 0 = FP32, the only format implemented
   parameter int unsigned NUM_STAGES = 1,   // 0..4, 0 = combinational passthrough
   parameter int unsigned TAG_WIDTH  = 5
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_flush,
   input  logic [3:1][31:0]        i_rs,
   input  logic [3:0]              i_op,
   input  logic [2:0]              i_rm,
   input  logic [TAG_WIDTH-1:0]    i_tag,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   output logic [31:0]             o_result,
   output logic [4:0]              o_fflags,
   output logic [TAG_WIDTH-1:0]    o_tag,
   output logic                    o_out_valid,
   input  logic                    i_out_ready
);

   localparam int unsigned FLEN = 32;
   localparam int unsigned PW   = FLEN + 5 + TAG_WIDTH;

   localparam logic [3:0] OP_FCMP    = 4'b0001;
   localparam logic [3:0] OP_FMINMAX = 4'b0010;
   localparam logic [3:0] OP_FSGNJ   = 4'b0100;
   localparam logic [3:0] OP_FCLASS  = 4'b1000;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;

   localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

   // rs3 is architecturally present but has no role in these operations
   logic unused_s;
   assign unused_s = ^i_rs[3];

   // RISC-V FCLASS one-hot mask for one FP32 operand
   function automatic logic [9:0] fclass(input logic [31:0] x);
      logic       s;
      logic       e_max;
      logic       e_zero;
      logic       m_zero;
      logic [9:0] m;
      s      = x[31];
      e_max  = &x[30:23];
      e_zero = ~|x[30:23];
      m_zero = ~|x[22:0];
      m      = 10'd0;
      if (e_max && !m_zero) begin
         m[9] = x[22];
         m[8] = ~x[22];
      end else if (e_max) begin
         m[0] = s;
         m[7] = ~s;
      end else if (e_zero && m_zero) begin
         m[3] = s;
         m[4] = ~s;
      end else if (e_zero) begin
         m[2] = s;
         m[5] = ~s;
      end else begin
         m[1] = s;
         m[6] = ~s;
      end
      return m;
   endfunction

   logic [31:0] a_s, b_s;
   logic        a_nan_s, b_nan_s, a_snan_s, b_snan_s;
   logic        any_nan_s, any_snan_s, both_zero_s;
   logic        mag_lt_s, mag_gt_s;
   logic        eq_s, lt_s, ltz_s;
   logic [31:0] res_s;
   logic [4:0]  flags_s;

   // operand classification and the two orderings (IEEE compare, signed-zero aware)
   always_comb begin
      a_s         = i_rs[1];
      b_s         = i_rs[2];
      a_nan_s     = (&a_s[30:23]) & (|a_s[22:0]);
      b_nan_s     = (&b_s[30:23]) & (|b_s[22:0]);
      a_snan_s    = a_nan_s & ~a_s[22];
      b_snan_s    = b_nan_s & ~b_s[22];
      any_nan_s   = a_nan_s | b_nan_s;
      any_snan_s  = a_snan_s | b_snan_s;
      both_zero_s = ~(|a_s[30:0]) & ~(|b_s[30:0]);
      mag_lt_s    = a_s[30:0] < b_s[30:0];
      mag_gt_s    = a_s[30:0] > b_s[30:0];
      eq_s        = (a_s == b_s) | both_zero_s;
      if (a_s[31] != b_s[31]) begin
         lt_s  = a_s[31] & ~both_zero_s;
         ltz_s = a_s[31];
      end else if (a_s[31] == 1'b0) begin
         lt_s  = mag_lt_s;
         ltz_s = mag_lt_s;
      end else begin
         lt_s  = mag_gt_s;
         ltz_s = mag_gt_s;
      end
   end

   // sub-operation select and result/flag formation
   always_comb begin
      res_s   = 32'd0;
      flags_s = 5'd0;
      case (i_op)
         OP_FCMP: begin
            case (i_rm)
               RM_RNE: begin
                  res_s   = {31'd0, (lt_s | eq_s) & ~any_nan_s};
                  flags_s = {any_nan_s, 4'd0};
               end
               RM_RTZ: begin
                  res_s   = {31'd0, lt_s & ~any_nan_s};
                  flags_s = {any_nan_s, 4'd0};
               end
               RM_RDN: begin
                  res_s   = {31'd0, eq_s & ~any_nan_s};
                  flags_s = {any_snan_s, 4'd0};
               end
               default: begin
                  res_s   = 32'd0;
                  flags_s = 5'd0;
               end
            endcase
         end
         OP_FMINMAX: begin
            if ((i_rm == RM_RNE) || (i_rm == RM_RTZ)) begin
               flags_s = {any_snan_s, 4'd0};
               if (a_nan_s && b_nan_s) begin
                  res_s = CANON_QNAN;
               end else if (a_nan_s) begin
                  res_s = b_s;
               end else if (b_nan_s) begin
                  res_s = a_s;
               end else if (i_rm == RM_RNE) begin
                  res_s = ltz_s ? a_s : b_s;
               end else begin
                  res_s = ltz_s ? b_s : a_s;
               end
            end else begin
               res_s   = 32'd0;
               flags_s = 5'd0;
            end
         end
         OP_FSGNJ: begin
            case (i_rm)
               RM_RNE:  res_s = {b_s[31], a_s[30:0]};
               RM_RTZ:  res_s = {~b_s[31], a_s[30:0]};
               RM_RDN:  res_s = {a_s[31] ^ b_s[31], a_s[30:0]};
               default: res_s = 32'd0;
            endcase
         end
         OP_FCLASS: begin
            res_s = {22'd0, fclass(a_s)};
         end
         default: begin
            res_s   = 32'd0;
            flags_s = 5'd0;
         end
      endcase
   end

   generate
      if (NUM_STAGES == 0) begin : g_comb
         logic unused_ctl_s;
         assign unused_ctl_s = i_clk ^ i_rst ^ i_flush;
         assign o_result     = res_s;
         assign o_fflags     = flags_s;
         assign o_tag        = i_tag;
         assign o_out_valid  = i_in_valid;
         assign o_in_ready   = i_out_ready;
      end else begin : g_pipe
         logic [NUM_STAGES-1:0] valid_q, valid_d;
         logic [PW-1:0]         data_q [NUM_STAGES];
         logic [PW-1:0]         data_d [NUM_STAGES];
         logic [NUM_STAGES:0]   ready_s;
         logic [NUM_STAGES:0]   vchain_s;
         logic [PW-1:0]         dchain_s [NUM_STAGES+1];

         // stage k may load when empty or when the stage after it can drain
         always_comb begin
            ready_s[NUM_STAGES] = i_out_ready;
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
               ready_s[k] = ~valid_q[k] | ready_s[k+1];
            end
         end

         // incoming valid/data seen by each stage (entry 0 is the request port)
         always_comb begin
            vchain_s[0] = i_in_valid;
            dchain_s[0] = {res_s, flags_s, i_tag};
            for (int k = 0; k < NUM_STAGES; k++) begin
               vchain_s[k+1] = valid_q[k];
               dchain_s[k+1] = data_q[k];
            end
         end

         // next state: flush empties every stage, otherwise load on ready
         always_comb begin
            for (int k = 0; k < NUM_STAGES; k++) begin
               valid_d[k] = valid_q[k];
               data_d[k]  = data_q[k];
               if (i_flush) begin
                  valid_d[k] = 1'b0;
               end else if (ready_s[k]) begin
                  valid_d[k] = vchain_s[k];
               end else begin
                  valid_d[k] = valid_q[k];
               end
               if (ready_s[k] && vchain_s[k] && !i_flush) begin
                  data_d[k] = dchain_s[k];
               end else begin
                  data_d[k] = data_q[k];
               end
            end
         end

         // stage registers, cleared asynchronously
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               valid_q <= '0;
               for (int k = 0; k < NUM_STAGES; k++) begin
                  data_q[k] <= '0;
               end
            end else begin
               valid_q <= valid_d;
               for (int k = 0; k < NUM_STAGES; k++) begin
                  data_q[k] <= data_d[k];
               end
            end
         end

         assign o_out_valid = valid_q[NUM_STAGES-1];
         assign o_in_ready  = ready_s[0];
         assign {o_result, o_fflags, o_tag} = data_q[NUM_STAGES-1];
      end
   endgenerate

endmodule

// File: tb/tb_fpu_fcmp_pipe.sv
// Directed bench for fpu_fcmp_pipe (FP32, two stages) with an in-order scoreboard.
module tb_fpu_fcmp_pipe;

   localparam logic [3:0] FCMP = 4'b0001;
   localparam logic [3:0] FMM  = 4'b0010;
   localparam logic [3:0] FSG  = 4'b0100;
   localparam logic [3:0] FCL  = 4'b1000;
   localparam logic [4:0] NV   = 5'b10000;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  fl;
      logic [4:0]  tag;
   } exp_t;

   logic              clk;
   logic              i_rst;
   logic              i_flush;
   logic [3:1][31:0]  i_rs;
   logic [3:0]        i_op;
   logic [2:0]        i_rm;
   logic [4:0]        i_tag;
   logic              i_in_valid;
   logic              o_in_ready;
   logic [31:0]       o_result;
   logic [4:0]        o_fflags;
   logic [4:0]        o_tag;
   logic              o_out_valid;
   logic              i_out_ready;

   logic [31:0]       exp_res;
   logic [4:0]        exp_fl;
   exp_t              sb [$];
   int                n_assert;
   int                n_fail;

   fpu_fcmp_pipe #(.FP_FMT(0), .NUM_STAGES(2), .TAG_WIDTH(5)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_rs(i_rs), .i_op(i_op),
      .i_rm(i_rm), .i_tag(i_tag), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .o_result(o_result), .o_fflags(o_fflags), .o_tag(o_tag),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // scoreboard: push on accepted request, pop and compare on output handshake
   always @(negedge clk or posedge i_rst) begin
      if (i_rst) begin
         sb.delete();
      end else begin
         if (i_in_valid && o_in_ready && !i_flush) begin
            sb.push_back('{res: exp_res, fl: exp_fl, tag: i_tag});
         end
         if (o_out_valid && i_out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 32'(sb.size()), 32'd1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", o_result, e.res);
               chk("fflags", 32'(o_fflags), 32'(e.fl));
               chk("tag", 32'(o_tag), 32'(e.tag));
            end
         end
         if (i_flush) begin
            sb.delete();
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic [2:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] er, input logic [4:0] ef);
      logic acc;
      i_op = op; i_rm = rm; i_rs[1] = a; i_rs[2] = b; i_rs[3] = 32'hDEAD_BEEF;
      i_tag = tag; exp_res = er; exp_fl = ef; i_in_valid = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 100 && !acc; n++) begin
         @(negedge clk);
         acc = o_in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic idle();
      i_in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      i_rst = 1'b1; i_flush = 1'b0; i_rs = '0; i_op = 4'd0; i_rm = 3'd0;
      i_tag = 5'd0; i_in_valid = 1'b0; i_out_ready = 1'b1;
      exp_res = 32'd0; exp_fl = 5'd0;
      #12;
      chk("rst_valid", 32'(o_out_valid), 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_fflags", 32'(o_fflags), 32'd0);
      chk("rst_tag", 32'(o_tag), 32'd0);
      @(posedge clk); #1;
      i_rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(o_in_ready), 32'd1);
      @(posedge clk); #1;

      // FLE with latency check: accepted this cycle, valid two cycles later
      send(FCMP, 3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd3, 32'd1, 5'd0);
      idle();
      @(negedge clk);
      chk("lat_cycle1_valid", 32'(o_out_valid), 32'd0);
      @(negedge clk);
      chk("lat_cycle2_valid", 32'(o_out_valid), 32'd1);
      chk("lat_cycle2_tag", 32'(o_tag), 32'd3);
      drain();
      @(posedge clk); #1;

      // directed function table, streamed back-to-back
      send(FMM,  3'd0, 32'h0000_0000, 32'h8000_0000, 5'd1,  32'h8000_0000, 5'd0);
      send(FMM,  3'd1, 32'h0000_0000, 32'h8000_0000, 5'd2,  32'h0000_0000, 5'd0);
      send(FMM,  3'd1, 32'h8000_0000, 32'h0000_0000, 5'd4,  32'h0000_0000, 5'd0);
      send(FMM,  3'd0, 32'h7FC0_0000, 32'h7FC0_0000, 5'd5,  32'h7FC0_0000, 5'd0);
      send(FMM,  3'd1, 32'h7FC0_0000, 32'h4040_0000, 5'd6,  32'h4040_0000, 5'd0);
      send(FMM,  3'd0, 32'h7F80_0001, 32'h3F80_0000, 5'd7,  32'h3F80_0000, NV);
      send(FMM,  3'd0, 32'hC000_0000, 32'hBF80_0000, 5'd8,  32'hC000_0000, 5'd0);
      send(FCMP, 3'd2, 32'h7F80_0001, 32'h3F80_0000, 5'd9,  32'd0, NV);
      send(FCMP, 3'd2, 32'h7FC0_0000, 32'h3F80_0000, 5'd10, 32'd0, 5'd0);
      send(FCMP, 3'd1, 32'h7FC0_0000, 32'h3F80_0000, 5'd11, 32'd0, NV);
      send(FCMP, 3'd0, 32'h7FC0_0000, 32'h3F80_0000, 5'd12, 32'd0, NV);
      send(FCMP, 3'd2, 32'h0000_0000, 32'h8000_0000, 5'd13, 32'd1, 5'd0);
      send(FCMP, 3'd1, 32'h0000_0000, 32'h8000_0000, 5'd14, 32'd0, 5'd0);
      send(FCMP, 3'd1, 32'hBF80_0000, 32'h3F80_0000, 5'd15, 32'd1, 5'd0);
      send(FCMP, 3'd1, 32'hC000_0000, 32'hBF80_0000, 5'd16, 32'd1, 5'd0);
      send(FCMP, 3'd0, 32'hBF80_0000, 32'hC000_0000, 5'd17, 32'd0, 5'd0);
      send(FSG,  3'd0, 32'h3F80_0000, 32'h8000_0000, 5'd18, 32'hBF80_0000, 5'd0);
      send(FSG,  3'd1, 32'h3F80_0000, 32'h8000_0000, 5'd19, 32'h3F80_0000, 5'd0);
      send(FSG,  3'd2, 32'hBF80_0000, 32'h8000_0000, 5'd20, 32'h3F80_0000, 5'd0);
      send(FSG,  3'd0, 32'h7F80_0001, 32'h8000_0000, 5'd21, 32'hFF80_0001, 5'd0);
      send(FCL,  3'd0, 32'h0000_0001, 32'h0,         5'd22, 32'h0000_0020, 5'd0);
      send(FCL,  3'd0, 32'h7FC0_0000, 32'h0,         5'd23, 32'h0000_0200, 5'd0);
      send(FCL,  3'd0, 32'h7F80_0001, 32'h0,         5'd24, 32'h0000_0100, 5'd0);
      send(FCL,  3'd0, 32'h8000_0000, 32'h0,         5'd25, 32'h0000_0008, 5'd0);
      send(FCL,  3'd0, 32'h3F80_0000, 32'h0,         5'd26, 32'h0000_0040, 5'd0);
      send(FCMP, 3'd3, 32'h7F80_0001, 32'h3F80_0000, 5'd27, 32'd0, 5'd0);
      send(FMM,  3'd2, 32'h3F80_0000, 32'h7F80_0001, 5'd28, 32'd0, 5'd0);
      send(4'b0011, 3'd0, 32'h3F80_0000, 32'h7F80_0001, 5'd29, 32'd0, 5'd0);
      send(4'b0000, 3'd0, 32'h7F80_0001, 32'h7F80_0001, 5'd30, 32'd0, 5'd0);
      idle();
      drain();
      @(posedge clk); #1;

      // six back-to-back ops while the consumer stalls for four cycles
      fork
         begin
            send(FCMP, 3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd10, 32'd1, 5'd0);
            send(FMM,  3'd1, 32'h3F80_0000, 32'h4000_0000, 5'd11, 32'h4000_0000, 5'd0);
            send(FSG,  3'd1, 32'h3F80_0000, 32'h3F80_0000, 5'd12, 32'hBF80_0000, 5'd0);
            send(FCL,  3'd0, 32'hFF80_0000, 32'h0,         5'd13, 32'h0000_0001, 5'd0);
            send(FCMP, 3'd2, 32'h4000_0000, 32'h4000_0000, 5'd14, 32'd1, 5'd0);
            send(FMM,  3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd15, 32'h3F80_0000, 5'd0);
            idle();
         end
         begin
            i_out_ready = 1'b0;
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            chk("stall_in_ready_a", 32'(o_in_ready), 32'd0);
            chk("stall_hold_tag", 32'(o_tag), 32'd10);
            @(negedge clk);
            chk("stall_in_ready_b", 32'(o_in_ready), 32'd0);
            chk("stall_hold_valid", 32'(o_out_valid), 32'd1);
            @(posedge clk); #1;
            i_out_ready = 1'b1;
         end
      join
      drain();
      @(posedge clk); #1;

      // flush with two held in flight and a valid request the same cycle
      i_out_ready = 1'b0;
      send(FCMP, 3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd1, 32'd1, 5'd0);
      send(FCMP, 3'd1, 32'h3F80_0000, 32'h4000_0000, 5'd2, 32'd1, 5'd0);
      i_op = FCL; i_rs[1] = 32'h3F80_0000; i_tag = 5'd3;
      exp_res = 32'h0000_0040; exp_fl = 5'd0;
      i_in_valid = 1'b1; i_flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(o_in_ready), 32'd0);
      @(posedge clk); #1;
      i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
      @(negedge clk);
      chk("flush_valid_1", 32'(o_out_valid), 32'd0);
      @(negedge clk);
      chk("flush_valid_2", 32'(o_out_valid), 32'd0);
      chk("flush_in_ready_after", 32'(o_in_ready), 32'd1);
      @(posedge clk); #1;
      send(FMM, 3'd1, 32'hBF80_0000, 32'h3F80_0000, 5'd4, 32'h3F80_0000, 5'd0);
      idle();
      drain();
      @(posedge clk); #1;

      // asynchronous reset in the middle of a stall
      i_out_ready = 1'b0;
      send(FCMP, 3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5, 32'd1, 5'd0);
      send(FCMP, 3'd2, 32'h3F80_0000, 32'h3F80_0000, 5'd6, 32'd1, 5'd0);
      i_op = FCMP; i_rm = 3'd1; i_tag = 5'd7; exp_res = 32'd0; exp_fl = 5'd0;
      i_in_valid = 1'b1;
      @(negedge clk);
      #2;
      i_rst = 1'b1;
      #1;
      chk("arst_valid", 32'(o_out_valid), 32'd0);
      chk("arst_result", o_result, 32'd0);
      chk("arst_tag", 32'(o_tag), 32'd0);
      chk("arst_fflags", 32'(o_fflags), 32'd0);
      i_in_valid = 1'b0;
      @(posedge clk); #1;
      i_rst = 1'b0; i_out_ready = 1'b1;
      @(negedge clk);
      chk("arst_in_ready", 32'(o_in_ready), 32'd1);
      @(posedge clk); #1;
      send(FCL, 3'd0, 32'hFF80_0000, 32'h0, 5'd8, 32'h0000_0001, 5'd0);
      idle();
      drain();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
